// File: rtl/i2c_slave_regif.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regif
// Purpose  : I2C target that turns bus transactions into register-file
//            accesses. The first written byte is the register pointer. Later
//            written bytes pulse reg_we. Reads fetch through reg_re/reg_rdata.
// Options  : I2C_SLAVE_AUTOINC_EN - advance the pointer after each ACKed byte
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regif #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl,
  inout  wire               sda,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              nack_seen
);

`ifdef I2C_SLAVE_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
  } state_t;

  state_t      state;
  logic        scl_s1, scl_s2, scl_q;
  logic        sda_s1, sda_s2, sda_q;
  logic [6:0]  shreg;      // receive history / remaining transmit bits
  logic [3:0]  bit_cnt;
  logic        rw;
  logic        ack_drv;    // ACK phase: low driven (or, in READ_ACK, master ACKed)
  logic        load_pend;  // reg_rdata is valid this cycle
  logic        sda_oe;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  rx_byte;

  // Open-drain pad: only ever pull low.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus a delayed copy for edge detection; idle bus is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_q <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_q <= 1'b1;
    end else begin
      scl_s1 <= scl;    scl_s2 <= scl_s1; scl_q <= scl_s2;
      sda_s1 <= sda;    sda_s2 <= sda_s1; sda_q <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_q;
  assign scl_fall  = ~scl_s2 & scl_q;
  assign start_det = scl_s2 & scl_q & sda_q & ~sda_s2;
  assign stop_det  = scl_s2 & scl_q & ~sda_q & sda_s2;
  assign rx_byte   = {shreg, sda_s2};

  // Protocol FSM with registered strobes, pointer and pad enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      rw        <= 1'b0;
      ack_drv   <= 1'b0;
      load_pend <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      nack_seen <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      nack_seen <= 1'b0;
      if (start_det) begin
        state     <= S_ADDR;
        bit_cnt   <= '0;
        sda_oe    <= 1'b0;
        ack_drv   <= 1'b0;
        load_pend <= 1'b0;
      end else if (stop_det) begin
        state     <= S_IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        ack_drv   <= 1'b0;
        load_pend <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  rw    <= rx_byte[0];
                  busy  <= 1'b1;
                  state <= S_ADDR_ACK;
                end else begin
                  busy  <= 1'b0;
                  state <= S_IGNORE;
                end
              end
            end
          end
          S_PTR, S_WRITE: begin
            if (scl_rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (state == S_PTR) begin
                  reg_addr <= ADDR_W'(rx_byte);
                  state    <= S_PTR_ACK;
                end else begin
                  reg_wdata <= rx_byte;
                  reg_we    <= 1'b1;
                  state     <= S_WRITE_ACK;
                end
              end
            end
          end
          // First fall after bit 8 starts the ACK; the following fall ends it.
          S_ADDR_ACK, S_PTR_ACK, S_WRITE_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                ack_drv <= 1'b1;
                sda_oe  <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                if (state == S_ADDR_ACK && rw) begin
                  state     <= S_READ;
                  reg_re    <= 1'b1;
                  load_pend <= 1'b1;
                end else if (state == S_ADDR_ACK) begin
                  state <= S_PTR;
                end else begin
                  state <= S_WRITE;
                  if (state == S_WRITE_ACK && AUTOINC)
                    reg_addr <= reg_addr + 1'b1;
                end
              end
            end
          end
          S_READ: begin
            if (load_pend) begin
              load_pend <= 1'b0;
              shreg     <= reg_rdata[6:0];
              sda_oe    <= ~reg_rdata[7];
              bit_cnt   <= '0;
            end else if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= S_READ_ACK;
              end else begin
                sda_oe <= ~shreg[6];
                shreg  <= {shreg[5:0], 1'b0};
              end
            end
          end
          S_READ_ACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                nack_seen <= 1'b1;
                busy      <= 1'b0;
                state     <= S_IGNORE;
              end else begin
                ack_drv <= 1'b1;
              end
            end else if (scl_fall && ack_drv) begin
              ack_drv   <= 1'b0;
              reg_re    <= 1'b1;
              load_pend <= 1'b1;
              state     <= S_READ;
              if (AUTOINC)
                reg_addr <= reg_addr + 1'b1;
            end
          end
          S_IDLE, S_IGNORE: begin
            sda_oe <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regif.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_regif
// Purpose  : Bench for i2c_slave_regif: bit-banged I2C master, bench-owned
//            register file, transaction-level reference model and strobe
//            scoreboard. Honours I2C_SLAVE_AUTOINC_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regif;
  localparam int Q  = 8;    // clk periods per quarter SCL period
  localparam int CP = 10;   // clk period
`ifdef I2C_SLAVE_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0, reset = 1'b1, scl = 1'b1, m_sda = 1'b1;
  wire  sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic reg_we, reg_re, busy, nack_seen;

  logic [7:0] regs    [256];   // bench register file seen by the DUT
  logic [7:0] mdl_mem [256];   // model's view of register contents
  logic [7:0] mdl_ptr;
  logic [7:0] dbuf [4];
  logic [7:0] rbuf [4];
  ev_t  exp_q [$];
  int   n_checks = 0, n_fail = 0, nack_cnt = 0, nack_exp = 0;
  logic [7:0] last_we_addr = 0, last_we_data = 0, last_re_addr = 0;

  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;
  assign reg_rdata = regs[reg_addr];

  always #5 clk = ~clk;

  i2c_slave_regif dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy), .nack_seen(nack_seen)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_q;
    #(Q*CP);
  endtask

  // ---------------- bit-level master ----------------
  task automatic bus_start;
    m_sda = 1'b1; scl = 1'b1; wait_q; m_sda = 1'b0; wait_q; scl = 1'b0; wait_q;
  endtask

  task automatic bus_rstart;
    m_sda = 1'b1; wait_q; scl = 1'b1; wait_q; m_sda = 1'b0; wait_q; scl = 1'b0; wait_q;
  endtask

  task automatic bus_stop;
    m_sda = 1'b0; wait_q; scl = 1'b1; wait_q; m_sda = 1'b1; wait_q; wait_q;
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; wait_q; scl = 1'b1; wait_q; wait_q; scl = 1'b0; wait_q;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; wait_q; scl = 1'b1; wait_q; ack = sda; wait_q; scl = 1'b0; wait_q;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; wait_q; scl = 1'b1; wait_q; b[i] = sda; wait_q; scl = 1'b0; wait_q;
    end
    m_sda = nack; wait_q; scl = 1'b1; wait_q; wait_q; scl = 1'b0; wait_q;
  endtask

  // ---------------- model helpers ----------------
  task automatic expect_ev(input logic we, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.we = we; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic finish_txn;
    check("busy_after_stop", busy, 0);
    check("pending_strobes", exp_q.size(), 0);
    check("nack_count", nack_cnt, nack_exp);
  endtask

  // Write n bytes from dbuf starting at ptr.
  task automatic txn_write(input logic [7:0] ptr, input int n);
    logic ack;
    mdl_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      expect_ev(1'b1, mdl_ptr, dbuf[i]);
      mdl_mem[mdl_ptr] = dbuf[i];
      mdl_ptr = mdl_ptr + 8'(INC);
    end
    bus_start;
    wr_byte(8'h84, ack); check("wr_addr_ack", ack, 0);
    check("busy_after_match", busy, 1);
    wr_byte(ptr, ack);   check("wr_ptr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      wr_byte(dbuf[i], ack); check("wr_data_ack", ack, 0);
    end
    bus_stop;
    finish_txn;
  endtask

  // Read n bytes into rbuf, optionally loading the pointer first.
  task automatic txn_read(input logic set_ptr, input logic [7:0] ptr, input int n);
    logic ack;
    logic [7:0] expb [4];
    if (set_ptr) mdl_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      expect_ev(1'b0, mdl_ptr, 8'h00);
      expb[i] = mdl_mem[mdl_ptr];
      if (i < n - 1) mdl_ptr = mdl_ptr + 8'(INC);
    end
    nack_exp++;
    bus_start;
    if (set_ptr) begin
      wr_byte(8'h84, ack); check("rd_waddr_ack", ack, 0);
      wr_byte(ptr, ack);   check("rd_ptr_ack", ack, 0);
      bus_rstart;
    end
    wr_byte(8'h85, ack); check("rd_addr_ack", ack, 0);
    check("busy_in_read", busy, 1);
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, rbuf[i]);
      check("rd_data", rbuf[i], expb[i]);
    end
    bus_stop;
    finish_txn;
  endtask

  task automatic txn_bad(input logic [6:0] a7, input logic rw);
    logic ack;
    bus_start;
    wr_byte({a7, rw}, ack); check("bad_addr_released", ack, 1);
    check("bad_addr_busy", busy, 0);
    wr_byte(8'h00, ack);    check("bad_data_released", ack, 1);
    bus_stop;
    finish_txn;
  endtask

  // ---------------- scoreboard / register file ----------------
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (reg_we && reg_re) check("strobe_overlap", 1, 0);
        if (reg_we || reg_re) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", {22'd0, reg_we, reg_re, reg_addr}, 0);
          end else begin
            e = exp_q.pop_front();
            check("strobe_kind", reg_we, e.we);
            check("strobe_addr", reg_addr, e.addr);
            if (e.we) check("strobe_wdata", reg_wdata, e.data);
          end
          if (reg_we) begin
            regs[reg_addr] = reg_wdata;
            last_we_addr   = reg_addr;
            last_we_data   = reg_wdata;
          end
          if (reg_re) last_re_addr = reg_addr;
        end
        if (nack_seen) nack_cnt++;
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] v;
    logic       ack;
    int         kind, n;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      regs[i] = v; mdl_mem[i] = v;
    end
    mdl_ptr = 8'h00;
    #(4*CP);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_reg_re", reg_re, 0);
    check("rst_busy", busy, 0);
    check("rst_nack_seen", nack_seen, 0);
    check("rst_sda", sda, 1);
    reset = 1'b0;
    #(10*CP);

    // Directed burst write.
    dbuf[0] = 8'hA5; dbuf[1] = 8'h5A;
    txn_write(8'h10, 2);
    check("burst_last_we_addr", last_we_addr, (INC != 0) ? 32'h11 : 32'h10);
    check("burst_last_we_data", last_we_data, 32'h5A);
    check("burst_final_ptr", reg_addr, (INC != 0) ? 32'h12 : 32'h10);

    // Combined write-pointer / repeated START / read.
    regs[8'h20] = 8'h3C; mdl_mem[8'h20] = 8'h3C;
    regs[8'h21] = 8'hC3; mdl_mem[8'h21] = 8'hC3;
    txn_read(1'b1, 8'h20, 2);
    check("comb_byte0", rbuf[0], 32'h3C);
    check("comb_byte1", rbuf[1], (INC != 0) ? 32'hC3 : 32'h3C);
    check("comb_last_re_addr", last_re_addr, (INC != 0) ? 32'h21 : 32'h20);
    check("comb_nack_total", nack_cnt, 1);

    // Address mismatch.
    txn_bad(7'h43, 1'b0);

    // STOP in the middle of a data byte.
    mdl_ptr = 8'h10;
    bus_start;
    wr_byte(8'h84, ack); check("midstop_addr_ack", ack, 0);
    wr_byte(8'h10, ack); check("midstop_ptr_ack", ack, 0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    bus_stop;
    check("midstop_ptr", reg_addr, 32'h10);
    finish_txn;

    // Randomized transactions, including pointer wrap.
    for (int t = 0; t < 20; t++) begin
      kind = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom);
      v = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      case (kind)
        0: txn_write(v, n);
        1: txn_read(1'b1, v, n);
        2: txn_read(1'b0, 8'h00, n);
        default: begin
          logic [6:0] a7;
          a7 = 7'($urandom);
          if (a7 == 7'h42) a7 = 7'h24;
          txn_bad(a7, 1'($urandom));
        end
      endcase
    end

    // Reset while the target drives a 0 data bit.
    regs[8'h30] = 8'h12; mdl_mem[8'h30] = 8'h12;
    mdl_ptr = 8'h30;
    expect_ev(1'b0, 8'h30, 8'h00);
    bus_start;
    wr_byte(8'h84, ack); check("rr_waddr_ack", ack, 0);
    wr_byte(8'h30, ack); check("rr_ptr_ack", ack, 0);
    bus_rstart;
    wr_byte(8'h85, ack); check("rr_addr_ack", ack, 0);
    check("rr_target_drives_low", sda, 0);
    #3 reset = 1'b1;
    #1;
    check("rr_sda_released", sda, 1);
    check("rr_reg_addr", reg_addr, 0);
    check("rr_busy", busy, 0);
    check("rr_strobes", {reg_we, reg_re, nack_seen}, 0);
    #(3*CP) reset = 1'b0;
    @(negedge clk);
    mdl_ptr = 8'h00;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("rr_ignored_bus", sda, 1);
    bus_stop;
    finish_txn;
    dbuf[0] = 8'h77;
    txn_write(8'h40, 1);
    check("rr_recovery_we_addr", last_we_addr, 32'h40);

    #(10*CP);
    check("final_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave_regif.md
# i2c_slave_regif

I2C target (slave) that decodes a bus master's transactions and turns them into register-file accesses on a local, single-clock register interface. It oversamples `scl`/`sda` in the system clock domain, detects START and STOP conditions, matches a 7-bit address, and takes the first written byte as a register pointer. Later bytes become register write strobes or read fetches. It sits opposite the team's I2C master on the same two-wire bus and lets an on-chip block be configured over I2C.

## Interface
- `SLAVE_ADDR`, 7'h42: 7-bit address this target responds to.
- `ADDR_W`, 8: register pointer width; pointer bits above `ADDR_W` are discarded.

- `clk`  in  1  system clock; must be at least 20x the SCL frequency.
- `reset`  in  1  asynchronous, active-high reset.
- `scl`  in  1  bus clock; the target never drives or stretches SCL.
- `sda`  inout  1  open-drain data; driven only to 0, otherwise `1'bz`.
- `reg_addr`  out  ADDR_W  current register pointer.
- `reg_wdata`  out  8  byte received from the master.
- `reg_we`  out  1  one-`clk` write strobe; qualifies `reg_addr`/`reg_wdata`.
- `reg_re`  out  1  one-`clk` read-fetch strobe for `reg_addr`.
- `reg_rdata`  in  8  read data, sampled on the `clk` after `reg_re`.
- `busy`  out  1  high from an address match until STOP or the transaction is abandoned.
- `nack_seen`  out  1  one-`clk` pulse when the master NACKs a read byte.

## Operation
- **Input conditioning.** `scl` and `sda` pass through 2-FF synchronizers. A registered previous value of each gives rise/fall detects.
- **START/STOP detection.**
  - START: `sda` falls while `scl` is high.
  - STOP: `sda` rises while `scl` is high.
  - Both take effect from any state, including mid-byte and mid-ACK.
  - START (including repeated START) -> ADDR with the bit counter cleared.
  - STOP -> IDLE, with `sda` released and `busy` cleared.
- **Bit timing.** Data bits are sampled on SCL rise. The target changes its driven SDA value only on SCL fall.
- **States:**
  - IDLE: wait for START.
  - ADDR: shift in 8 bits (address + R/W).
    - On a match -> ADDR_ACK.
    - On a mismatch -> IGNORE.
  - ADDR_ACK: drive 0 from the SCL fall after bit 8 until the next SCL fall.
    - If R/W=0 -> PTR.
    - If R/W=1 -> READ; the first read byte is fetched at entry.
  - PTR: shift in 8 bits, load `reg_addr`, ACK, then -> WRITE.
  - WRITE: shift in 8 bits.
    - On the 8th SCL rise, set `reg_wdata` and pulse `reg_we` once, with `reg_addr` stable.
    - ACK, then advance the pointer (see Configuration). Stay in WRITE.
  - READ:
    - Fetch: pulse `reg_re`, load the shift register from `reg_rdata` one `clk` later, and drive MSB-first bits (0 = drive low, 1 = release).
    - After 8 bits, release `sda` on the SCL fall and sample the master's ACK on the 9th SCL rise.
    - ACK (0): advance the pointer and fetch the next byte at the 9th SCL fall.
    - NACK (1): pulse `nack_seen` and go to IGNORE.
  - IGNORE: `sda` released; wait for START or STOP.
- **Pointer width.** The pointer wraps modulo 2^ADDR_W.
- **Zero-data write.** An address+pointer write with no data bytes sets `reg_addr` only. This allows write-pointer / repeated-START / read sequences.

## Timing
- **Reset values:** state IDLE, `sda` = `1'bz`, `reg_addr` 0, `reg_wdata` 0, `reg_we` 0, `reg_re` 0, `busy` 0, `nack_seen` 0.
- **Detection latency:** SCL/SDA edges are acted on 3 `clk` after the pin transition (2 sync + 1 edge detect).
- **SDA output timing:**
  - The driven SDA value is updated within 4 `clk` of SCL fall.
  - An ACK is held through the whole high phase of the 9th clock.
- **Register read latency:** `reg_rdata` is captured exactly 1 `clk` after `reg_re`. The interface must present combinational or 1-cycle read data.
- **Strobe timing:** `reg_we`/`reg_re` are never asserted in the same `clk`, and never more than once per byte.
- **Reset mid-transaction:** `sda` is released immediately (asynchronously) and the target ignores the bus until the next START.

## Configuration
- Macro: `I2C_SLAVE_AUTOINC_EN`.
  - **Defined:** `reg_addr` increments by 1 (with wrap) after each written byte is ACKed and after each read byte the master ACKs.
  - **Undefined:** `reg_addr` changes only in PTR. Burst writes hit the same register repeatedly, and burst reads return the same register repeatedly.

## Test plan
- **Write with auto-increment.** START, 0x84 (addr 0x42, W), 0x10, 0xA5, 0x5A, STOP -> target ACKs all 4 bytes.
  - `reg_we` pulses twice: (0x10, 0xA5), then (0x11, 0x5A).
  - `busy` falls at STOP.
- **Combined write/read.** START, 0x84, 0x20, repeated START, 0x85, master reads 2 bytes (ACK, then NACK), STOP.
  - Register model returns 0x3C, 0xC3 -> master sees 0x3C, 0xC3.
  - `reg_re` fires at 0x20 and 0x21; `nack_seen` pulses once.
- **Address mismatch.** START, 0x86 -> SDA stays released on the 9th clock; no strobes; `busy` stays 0 until STOP.
- **STOP mid-byte.** START, 0x84, 0x10, 4 bits of data, then STOP -> no `reg_we`; state returns to IDLE; the next full transaction works normally.
- **Reset during a read.** Assert `reset` while the target drives a 0 bit -> `sda` goes z immediately; all outputs hold reset values.
- **Auto-increment disabled.** With `I2C_SLAVE_AUTOINC_EN` undefined, repeat the first write -> both `reg_we` pulses occur at `reg_addr` 0x10.
